// File: rtl/seg_scan_decoder_if.sv
// Bus bundle for seg_scan_decoder: multiplexed display sample in, decoded frame out
// with a valid/ready handshake and a sticky overrun flag.
interface seg_scan_decoder_if;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] value;
  logic        valid;
  logic        ready;
  logic        err;
  logic [1:0]  err_digit;
  logic        overrun;

  // Producer of display samples and consumer of frames
  modport master (
    output seg, an, ready,
    input  value, valid, err, err_digit, overrun
  );

  // The decoder itself
  modport slave (
    input  seg, an, ready,
    output value, valid, err, err_digit, overrun
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Scanned 7-segment display decoder. Samples {an, seg}, captures each digit once it has
// been stable for SETTLE cycles, and emits a 4-digit frame through a valid/ready port.
// Optional macro SEG_BLANK_EN: when defined, an all-off pattern decodes as 0 instead of bad.
module seg_scan_decoder #(
  parameter int unsigned SETTLE = 2
) (
  input logic           clk,
  input logic           rst_n,
  seg_scan_decoder_if.slave bus
);

  localparam logic [3:0] SettleCnt = 4'(SETTLE);

  logic [10:0] sample;
  logic [10:0] sample_q;
  logic [3:0]  cnt_d, cnt_q;
  logic [3:0]  mask_d, mask_q;
  logic [15:0] digits_d, digits_q;
  logic [3:0]  bad_d, bad_q;
  logic [15:0] value_d, value_q;
  logic        valid_d, valid_q;
  logic        err_d, err_q;
  logic [1:0]  err_digit_d, err_digit_q;
  logic        overrun_d, overrun_q;

  logic        onehot, stable, capture, complete, load, accept;
  logic [3:0]  nib;
  logic        nib_bad;
  logic [1:0]  dig_idx;
  logic [15:0] frame_digits;
  logic [3:0]  frame_bad;
  logic [1:0]  frame_err_digit;

  assign sample = {bus.an, bus.seg};
  assign onehot = $onehot(bus.an);

  // Segment pattern to hex nibble; unknown patterns flag bad and read as 0
  always_comb begin
    nib     = 4'h0;
    nib_bad = 1'b0;
    case (bus.seg)
      7'h7E: nib = 4'h0;
      7'h30: nib = 4'h1;
      7'h6D: nib = 4'h2;
      7'h79: nib = 4'h3;
      7'h33: nib = 4'h4;
      7'h5B: nib = 4'h5;
      7'h5F: nib = 4'h6;
      7'h70: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h7B: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h1F: nib = 4'hB;
      7'h4E: nib = 4'hC;
      7'h3D: nib = 4'hD;
      7'h4F: nib = 4'hE;
      7'h47: nib = 4'hF;
`ifdef SEG_BLANK_EN
      7'h00: nib = 4'h0;
`endif
      default: nib_bad = 1'b1;
    endcase
  end

  // Digit index from the one-hot enable; only meaningful when onehot is set
  always_comb begin
    dig_idx = 2'd0;
    unique case (bus.an)
      4'b0001: dig_idx = 2'd0;
      4'b0010: dig_idx = 2'd1;
      4'b0100: dig_idx = 2'd2;
      4'b1000: dig_idx = 2'd3;
      default: dig_idx = 2'd0;
    endcase
  end

  // Stability counter, capture decision and frame assembly
  always_comb begin
    stable = (sample == sample_q) && onehot;
    if (stable) begin
      cnt_d = (cnt_q >= SettleCnt) ? cnt_q : cnt_q + 4'd1;
    end else begin
      cnt_d = 4'd1;
    end
    // A saturated counter that stays saturated must not recapture
    capture = onehot && (cnt_d == SettleCnt) && !(stable && (cnt_q == SettleCnt));

    frame_digits = digits_q;
    frame_bad    = bad_q;
    if (capture) begin
      frame_digits[{dig_idx, 2'b00} +: 4] = nib;
      frame_bad[dig_idx]                  = nib_bad;
    end
    complete = capture && ((mask_q | bus.an) == 4'hF);

    if (complete) begin
      mask_d = 4'h0;
    end else if (capture) begin
      mask_d = mask_q | bus.an;
    end else begin
      mask_d = mask_q;
    end
    digits_d = frame_digits;
    bad_d    = frame_bad;

    if (frame_bad[0])      frame_err_digit = 2'd0;
    else if (frame_bad[1]) frame_err_digit = 2'd1;
    else if (frame_bad[2]) frame_err_digit = 2'd2;
    else if (frame_bad[3]) frame_err_digit = 2'd3;
    else                   frame_err_digit = 2'd0;
  end

  // Output holding register, handshake and overrun tracking
  always_comb begin
    value_d     = value_q;
    valid_d     = valid_q;
    err_d       = err_q;
    err_digit_d = err_digit_q;
    overrun_d   = overrun_q;
    accept      = valid_q && bus.ready;
    load        = complete && (!valid_q || bus.ready);
    if (load) begin
      value_d     = frame_digits;
      valid_d     = 1'b1;
      err_d       = |frame_bad;
      err_digit_d = frame_err_digit;
    end else if (accept) begin
      valid_d = 1'b0;
    end
    if (accept) begin
      overrun_d = 1'b0;
    end
    if (complete && !load) begin
      overrun_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_q    <= '0;
      cnt_q       <= '0;
      mask_q      <= '0;
      digits_q    <= '0;
      bad_q       <= '0;
      value_q     <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      err_digit_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      sample_q    <= sample;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      digits_q    <= digits_d;
      bad_q       <= bad_d;
      value_q     <= value_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      err_digit_q <= err_digit_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.value     = value_q;
  assign bus.valid     = valid_q;
  assign bus.err       = err_q;
  assign bus.err_digit = err_digit_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter SETTLE, default 2, meaning consecutive identical-sample cycles required before a digit is captured (legal 1..15).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 SHALL have port seg  input  7  segment pattern, active-high, seg[6]=a ... seg[0]=g.
REQ-005 SHALL have port an  input  4  digit enable, active-high, an[k] selects digit k (k=3 most significant).
REQ-006 SHALL have port value  output  16  decoded frame, value[4k+3:4k] = digit k.
REQ-007 SHALL have port valid  output  1  value/err/err_digit hold a frame not yet accepted.
REQ-008 SHALL have port ready  input  1  consumer accepts frame when valid && ready at a rising edge.
REQ-009 SHALL have port err  output  1  frame held contains at least one undecodable digit.
REQ-010 SHALL have port err_digit  output  2  lowest-index undecodable digit of held frame; 0 when err=0.
REQ-011 SHALL have port overrun  output  1  sticky: a completed frame was dropped because the output was occupied.

Function
REQ-012 SHALL decode patterns: 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9, 77->A, 1F->b, 4E->C, 3D->d, 4F->E, 47->F (hex); any other pattern is bad, nibble 0.
REQ-013 SHALL treat {an, seg} as a sample; stability counter increments while the sample equals the previous cycle's sample and an is one-hot, and reloads to 1 otherwise.
REQ-014 SHALL capture digit k exactly once per continuous stable period, in the cycle the counter reaches SETTLE with an one-hot at bit k; counter saturates, no recapture until sample changes.
REQ-015 SHALL ignore samples with an = 0000 or more than one bit set (no capture, counter reload).
REQ-016 SHALL keep a 4-bit capture mask; recapture of an already-captured digit before frame completion overwrites that digit and its bad flag.
REQ-017 SHALL complete a frame in the cycle the mask becomes 1111; valid asserts on the next rising edge (latency 1 cycle from final capture).
REQ-018 SHALL, on completion, load value/err/err_digit and set valid if valid=0 or (valid && ready) in that cycle; otherwise drop the frame and set overrun.
REQ-019 SHALL clear the mask on completion whether the frame is loaded or dropped.
REQ-020 SHALL hold value, err, err_digit stable while valid=1 and ready=0; valid deasserts the cycle after acceptance unless a new frame loads in the same edge.
REQ-021 SHALL clear overrun only on an accepting handshake (valid && ready) or reset.

Reset
REQ-022 SHALL, when rst_n=0 at a rising edge, set value=0, valid=0, err=0, err_digit=0, overrun=0, mask=0, counter=0, previous sample=0.
REQ-023 SHALL discard any partial frame and any held frame on reset; first capture after reset requires a full SETTLE period.

Configuration
REQ-024 SHALL honour macro SEG_BLANK_EN: when defined, pattern 00 (all segments off) decodes as nibble 0, not bad; when undefined, 00 is bad.

Verification
REQ-025 Scan digits 3..0 with 6D,30,5B,7E, each held 4 cycles, ready=1 -> value=16'h2150, valid one cycle after digit 0 capture, err=0.
REQ-026 Digit 1 shows 7C, others valid -> err=1, err_digit=1, value[7:4]=0; with SEG_BLANK_EN, digit 1 shows 00 -> err=0.
REQ-027 Each digit held exactly SETTLE-1 cycles -> no capture, valid stays 0; held SETTLE cycles -> captured.
REQ-028 Two complete frames with ready=0 -> first frame held unchanged, overrun=1; then ready=1 one cycle -> valid=0, overrun=0.
REQ-029 an=0110 for 10 cycles mid-scan -> no capture, mask unchanged; frame completes after legal digits resume.
REQ-030 rst_n=0 one cycle after 3 digits captured -> all outputs 0; next frame needs all 4 digits again.
